// File: rtl/button_image_select.sv
// Button front-end for image selection: synchronises and debounces the left/right buttons,
// emits one-cycle press pulses and keeps the wrap-around image index.
module button_image_select #(
  parameter int   NUM_IMAGES      = 4,
  parameter int   SEL_W           = 2,
  parameter int   INIT_IMAGE      = 0,
  parameter int   DEBOUNCE_CYCLES = 1000000,
  parameter int   CNT_W           = 20,
  parameter logic PRESS_LEVEL     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             left_button,
  input  logic             right_button,
  output logic [SEL_W-1:0] select_image,
  output logic             left_pulse,
  output logic             right_pulse,
  output logic             left_pressed,
  output logic             right_pressed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_IMAGES - 1);
  localparam logic [SEL_W-1:0] IDX_INIT = SEL_W'(INIT_IMAGE);

  // Channel vectors: bit 0 is the left button, bit 1 the right button.
  logic [1:0]       btn;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       sample, hit;
  logic [1:0]       pressed_q, pressed_d;
  logic [1:0]       pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [SEL_W-1:0] idx_q, idx_d;

  always_comb begin
    btn       = {right_button, left_button};
    sample    = '0;
    hit       = '0;
    pressed_d = pressed_q;
    pulse_d   = '0;
    cnt_d[0]  = '0;
    cnt_d[1]  = '0;
    for (int i = 0; i < 2; i++) begin
      sample[i] = (sync2_q[i] == PRESS_LEVEL);
      // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
      hit[i]    = (sample[i] != pressed_q[i]) && (cnt_q[i] == CNT_LAST);
      if ((sample[i] == pressed_q[i]) || hit[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      pressed_d[i] = pressed_q[i] ^ hit[i];
      pulse_d[i]   = hit[i] & ~pressed_q[i];
    end
  end

  always_comb begin
    idx_d = idx_q;
    case (pulse_d)
      2'b10:   idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + SEL_W'(1);
      2'b01:   idx_d = (idx_q == '0) ? IDX_LAST : idx_q - SEL_W'(1);
      default: idx_d = idx_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= {2{~PRESS_LEVEL}};
      sync2_q   <= {2{~PRESS_LEVEL}};
      pressed_q <= '0;
      pulse_q   <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      idx_q     <= IDX_INIT;
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      pressed_q <= pressed_d;
      pulse_q   <= pulse_d;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
      idx_q     <= idx_d;
    end
  end

  assign select_image  = idx_q;
  assign left_pulse    = pulse_q[0];
  assign right_pulse   = pulse_q[1];
  assign left_pressed  = pressed_q[0];
  assign right_pressed = pressed_q[1];

endmodule
